// File: rtl/id_stage_pipe.sv
// id_stage_pipe: registered RV32I decode stage between the IF and EX pipeline
// registers. Full base-integer decode with sign-extended immediates, load-use
// hazard detection against EX, and branch flush. One output register holds
// the decoded bundle; valid/ready handshake on both sides.
//
// Optional build macro: ID_STALL_CNT_EN adds stall_cnt_o, a saturating count
// of cycles stalled by a load-use hazard (flush cycles excluded).
//
// Ports:
//   clk, rst                      clock (rising), async active-high reset
//   in_valid_i / in_ready_o       input handshake for instr_i / pc_i
//   flush_i                       kill held and incoming instruction
//   ex_memread_i, ex_rd_i         load in EX and its destination register
//   out_valid_o / out_ready_i     output handshake for the decoded bundle
//   pc_o, rs1/rs2/rd_addr_o       PC and register addresses (0 when unused)
//   imm_o, funct_o, aluctr_o      immediate, funct3, ALU operation
//   branch_o .. immadd_o, jump_o  control bits; jump 01 JAL, 10 JALR
//   illegal_o                     unknown opcode or funct encoding
module id_stage_pipe #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned ALUCTR_W       = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [31:0]               instr_i,
  input  logic [XLEN-1:0]           pc_i,
  input  logic                      flush_i,
  input  logic                      ex_memread_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [XLEN-1:0]           pc_o,
  output logic [REG_ADDR_WIDTH-1:0] rs1_addr_o,
  output logic [REG_ADDR_WIDTH-1:0] rs2_addr_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
  output logic [XLEN-1:0]           imm_o,
  output logic [2:0]                funct_o,
  output logic [ALUCTR_W-1:0]       aluctr_o,
  output logic                      branch_o,
  output logic                      memread_o,
  output logic                      memtoreg_o,
  output logic                      memwrite_o,
  output logic                      regwrite_o,
  output logic                      immadd_o,
  output logic [1:0]                jump_o,
  output logic                      illegal_o
`ifdef ID_STALL_CNT_EN
  ,
  output logic [31:0]               stall_cnt_o
`endif
);

  typedef enum logic [6:0] {
    OPC_R     = 7'b0110011,
    OPC_I     = 7'b0010011,
    OPC_L     = 7'b0000011,
    OPC_S     = 7'b0100011,
    OPC_B     = 7'b1100011,
    OPC_JAL   = 7'b1101111,
    OPC_JALR  = 7'b1100111,
    OPC_LUI   = 7'b0110111,
    OPC_AUIPC = 7'b0010111
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_NONE  = 4'd0,  ALU_ADD  = 4'd1,  ALU_SUB = 4'd2,  ALU_AND   = 4'd3,
    ALU_SLL   = 4'd4,  ALU_SRL  = 4'd5,  ALU_LUI = 4'd6,  ALU_AUIPC = 4'd7,
    ALU_OR    = 4'd8,  ALU_XOR  = 4'd9,  ALU_SLT = 4'd10, ALU_SLTU  = 4'd11,
    ALU_SRA   = 4'd12
  } aluop_e;

  logic [2:0] f3;
  logic [6:0] f7;
  assign f3 = instr_i[14:12];
  assign f7 = instr_i[31:25];

  aluop_e             alu;
  logic signed [31:0] imm32;
  logic use_rs1, use_rs2, use_rd, wr, bad;
  logic br, mrd, m2r, mwr, imma;
  logic [1:0] jmp;

  // Base decode of the incoming word; illegal encodings are masked below.
  always_comb begin
    alu = ALU_NONE; imm32 = '0; use_rs1 = 1'b0; use_rs2 = 1'b0; use_rd = 1'b0;
    wr = 1'b0; bad = 1'b0; br = 1'b0; mrd = 1'b0; m2r = 1'b0; mwr = 1'b0;
    imma = 1'b0; jmp = 2'b00;
    case (opcode_e'(instr_i[6:0]))
      OPC_R: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; wr = 1'b1;
        bad = !((f7 == 7'b0000000) ||
                (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
        case (f3)
          3'b000:  alu = f7[5] ? ALU_SUB : ALU_ADD;
          3'b001:  alu = ALU_SLL;
          3'b010:  alu = ALU_SLT;
          3'b011:  alu = ALU_SLTU;
          3'b100:  alu = ALU_XOR;
          3'b101:  alu = f7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  alu = ALU_OR;
          default: alu = ALU_AND;
        endcase
      end
      OPC_I: begin
        use_rs1 = 1'b1; use_rd = 1'b1; wr = 1'b1; imma = 1'b1;
        imm32 = 32'(signed'(instr_i[31:20]));
        case (f3)
          3'b000:  alu = ALU_ADD;
          3'b001: begin alu = ALU_SLL; bad = (f7 != 7'b0000000); end
          3'b010:  alu = ALU_SLT;
          3'b011:  alu = ALU_SLTU;
          3'b100:  alu = ALU_XOR;
          3'b101: begin
            alu = instr_i[30] ? ALU_SRA : ALU_SRL;
            bad = (f7 != 7'b0000000) && (f7 != 7'b0100000);
          end
          3'b110:  alu = ALU_OR;
          default: alu = ALU_AND;
        endcase
      end
      OPC_L: begin
        use_rs1 = 1'b1; use_rd = 1'b1; wr = 1'b1; imma = 1'b1;
        mrd = 1'b1; m2r = 1'b1; alu = ALU_ADD;
        imm32 = 32'(signed'(instr_i[31:20]));
        bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_S: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; mwr = 1'b1; imma = 1'b1; alu = ALU_ADD;
        imm32 = 32'(signed'({instr_i[31:25], instr_i[11:7]}));
        bad = f3[2] || (f3 == 3'b011);
      end
      OPC_B: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; br = 1'b1;
        imm32 = 32'(signed'({instr_i[31], instr_i[7], instr_i[30:25],
                             instr_i[11:8], 1'b0}));
        bad = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_JAL: begin
        use_rd = 1'b1; wr = 1'b1; jmp = 2'b01;
        imm32 = 32'(signed'({instr_i[31], instr_i[19:12], instr_i[20],
                             instr_i[30:21], 1'b0}));
      end
      OPC_JALR: begin
        use_rs1 = 1'b1; use_rd = 1'b1; wr = 1'b1; jmp = 2'b10;
        imm32 = 32'(signed'(instr_i[31:20]));
        bad = (f3 != 3'b000);
      end
      OPC_LUI: begin
        use_rd = 1'b1; wr = 1'b1; alu = ALU_LUI;
        imm32 = {instr_i[31:12], 12'h000};
      end
      OPC_AUIPC: begin
        use_rd = 1'b1; wr = 1'b1; alu = ALU_AUIPC;
        imm32 = {instr_i[31:12], 12'h000};
      end
      default: bad = 1'b1;
    endcase
  end

  logic [REG_ADDR_WIDTH-1:0] rs1_d, rs2_d, rd_d;
  logic [XLEN-1:0]           imm_d;
  logic [ALUCTR_W-1:0]       aluctr_d;
  logic [5:0]                ctl_d;   // branch, memread, memtoreg, memwrite, regwrite, immadd
  logic [1:0]                jump_d;

  // An illegal encoding flows as a valid bundle with everything but
  // illegal/funct cleared, so it never reads, writes or stalls.
  always_comb begin
    rs1_d    = (use_rs1 && !bad) ? REG_ADDR_WIDTH'(instr_i[19:15]) : '0;
    rs2_d    = (use_rs2 && !bad) ? REG_ADDR_WIDTH'(instr_i[24:20]) : '0;
    rd_d     = (use_rd  && !bad) ? REG_ADDR_WIDTH'(instr_i[11:7])  : '0;
    imm_d    = bad ? '0 : XLEN'(imm32);
    aluctr_d = bad ? '0 : ALUCTR_W'(alu);
    ctl_d    = bad ? '0 : {br, mrd, m2r, mwr, wr && (instr_i[11:7] != 5'd0), imma};
    jump_d   = bad ? '0 : jmp;
  end

  logic valid_q, valid_d, hazard, xfer;

  assign hazard = ex_memread_i && (ex_rd_i != '0) && in_valid_i &&
                  ((use_rs1 && !bad && rs1_d == ex_rd_i) ||
                   (use_rs2 && !bad && rs2_d == ex_rd_i));
  assign in_ready_o = (!valid_q || out_ready_i) && !hazard;
  assign xfer       = in_valid_i && in_ready_o && !flush_i;

  always_comb begin
    valid_d = valid_q;
    if (flush_i)          valid_d = 1'b0;
    else if (xfer)        valid_d = 1'b1;
    else if (out_ready_i) valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_o <= '0; rs1_addr_o <= '0; rs2_addr_o <= '0; rd_addr_o <= '0;
      imm_o <= '0; funct_o <= '0; aluctr_o <= '0; jump_o <= '0; illegal_o <= 1'b0;
      {branch_o, memread_o, memtoreg_o, memwrite_o, regwrite_o, immadd_o} <= '0;
    end else begin
      valid_q <= valid_d;
      if (xfer) begin
        pc_o <= pc_i; rs1_addr_o <= rs1_d; rs2_addr_o <= rs2_d; rd_addr_o <= rd_d;
        imm_o <= imm_d; funct_o <= f3; aluctr_o <= aluctr_d; jump_o <= jump_d;
        illegal_o <= bad;
        {branch_o, memread_o, memtoreg_o, memwrite_o, regwrite_o, immadd_o} <= ctl_d;
      end
    end
  end

  assign out_valid_o = valid_q;

`ifdef ID_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         stall_cnt_q <= '0;
    else if (hazard && !flush_i && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
  end
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_stage_pipe.sv
module tb_id_stage_pipe;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  alu;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [2:0]  funct;
    logic [8:0]  ctrl;   // branch,memread,memtoreg,memwrite,regwrite,immadd,jump[1:0],illegal
  } exp_t;

  typedef struct packed {
    logic [31:0] instr;
    exp_t        e;
  } stim_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid_i = 1'b0, flush_i = 1'b0, ex_memread_i = 1'b0, out_ready_i = 1'b1;
  logic [31:0] instr_i = '0, pc_i = '0;
  logic [4:0]  ex_rd_i = '0;
  logic        in_ready_o, out_valid_o;
  logic [31:0] pc_o, imm_o;
  logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic [2:0]  funct_o;
  logic [3:0]  aluctr_o;
  logic        branch_o, memread_o, memtoreg_o, memwrite_o, regwrite_o, immadd_o, illegal_o;
  logic [1:0]  jump_o;
`ifdef ID_STALL_CNT_EN
  logic [31:0] stall_cnt_o;
`endif

  id_stage_pipe #(.XLEN(32), .REG_ADDR_WIDTH(5), .ALUCTR_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .instr_i(instr_i), .pc_i(pc_i), .flush_i(flush_i), .ex_memread_i(ex_memread_i),
    .ex_rd_i(ex_rd_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .pc_o(pc_o), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o),
    .imm_o(imm_o), .funct_o(funct_o), .aluctr_o(aluctr_o), .branch_o(branch_o),
    .memread_o(memread_o), .memtoreg_o(memtoreg_o), .memwrite_o(memwrite_o),
    .regwrite_o(regwrite_o), .immadd_o(immadd_o), .jump_o(jump_o), .illegal_o(illegal_o)
`ifdef ID_STALL_CNT_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0, n_fail = 0;
  int unsigned m_stall = 0;
  logic        m_valid = 1'b0;
  exp_t        sb[$];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] alu, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic [31:0] imm,
                              input logic [2:0] funct, input logic [8:0] ctrl);
    exp_t e;
    e.pc = '0; e.alu = alu; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
    e.imm = imm; e.funct = funct; e.ctrl = ctrl;
    return e;
  endfunction

  // One cycle: drive at negedge, check outputs and in_ready, advance the model.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc, input exp_t e,
                      input logic fl, input logic mr, input logic [4:0] exrd,
                      input logic ordy, input logic hz);
    logic rdy;
    exp_t h;
    in_valid_i = v; instr_i = ins; pc_i = pc; flush_i = fl;
    ex_memread_i = mr; ex_rd_i = exrd; out_ready_i = ordy;
    #1;
    rdy = (!m_valid || ordy) && !hz;
    check_eq("in_ready", in_ready_o, rdy);
    check_eq("out_valid", out_valid_o, m_valid);
`ifdef ID_STALL_CNT_EN
    check_eq("stall_cnt", stall_cnt_o, m_stall);
`endif
    if (m_valid && sb.size() != 0) begin
      h = sb[0];
      check_eq("pc", pc_o, h.pc);
      check_eq("aluctr", aluctr_o, h.alu);
      check_eq("rs1", rs1_addr_o, h.rs1);
      check_eq("rs2", rs2_addr_o, h.rs2);
      check_eq("rd", rd_addr_o, h.rd);
      check_eq("imm", imm_o, h.imm);
      check_eq("funct", funct_o, h.funct);
      check_eq("ctrl", {branch_o, memread_o, memtoreg_o, memwrite_o, regwrite_o,
                        immadd_o, jump_o, illegal_o}, h.ctrl);
    end
    if (fl) begin
      if (m_valid && sb.size() != 0) void'(sb.pop_front());
      m_valid = 1'b0;
    end else begin
      if (m_valid && ordy) begin
        if (sb.size() != 0) void'(sb.pop_front());
        m_valid = 1'b0;
      end
      if (v && rdy) begin
        h = e; h.pc = pc;
        sb.push_back(h);
        m_valid = 1'b1;
      end
    end
    if (hz && !fl) m_stall++;
    @(negedge clk);
  endtask

  stim_t tab[14];
  exp_t  e_add656, e_addi, e_xor, e_sub, e_beq, e_ill, e_add, nil;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    e_add    = mk(4'd1, 5'd1, 5'd2, 5'd3, 32'h0, 3'd0, 9'b000010000);
    e_addi   = mk(4'd1, 5'd0, 5'd0, 5'd5, 32'hFFFFFFFF, 3'd0, 9'b000011000);
    e_sub    = mk(4'd2, 5'd3, 5'd4, 5'd7, 32'h0, 3'd0, 9'b000010000);
    e_xor    = mk(4'd9, 5'd1, 5'd2, 5'd3, 32'h0, 3'd4, 9'b000010000);
    e_beq    = mk(4'd0, 5'd1, 5'd2, 5'd0, 32'h8, 3'd0, 9'b100000000);
    e_ill    = mk(4'd0, 5'd0, 5'd0, 5'd0, 32'h0, 3'd7, 9'b000000001);
    e_add656 = mk(4'd1, 5'd5, 5'd1, 5'd6, 32'h0, 3'd0, 9'b000010000);
    nil      = mk(4'd0, 5'd0, 5'd0, 5'd0, 32'h0, 3'd0, 9'b0);
    tab[0]  = '{32'h002081B3, e_add};
    tab[1]  = '{32'hFFF00293, e_addi};
    tab[2]  = '{32'h404183B3, e_sub};
    tab[3]  = '{32'h4034D413, mk(4'd12, 5'd9, 5'd0, 5'd8, 32'h403, 3'd5, 9'b000011000)};
    tab[4]  = '{32'hFFC12503, mk(4'd1, 5'd2, 5'd0, 5'd10, 32'hFFFFFFFC, 3'd2, 9'b011011000)};
    tab[5]  = '{32'h00532423, mk(4'd1, 5'd6, 5'd5, 5'd0, 32'h8, 3'd2, 9'b000101000)};
    tab[6]  = '{32'h00208463, e_beq};
    tab[7]  = '{32'h010000EF, mk(4'd0, 5'd0, 5'd0, 5'd1, 32'h10, 3'd0, 9'b000010010)};
    tab[8]  = '{32'h00008067, mk(4'd0, 5'd1, 5'd0, 5'd0, 32'h0, 3'd0, 9'b000000100)};
    tab[9]  = '{32'h12345237, mk(4'd6, 5'd0, 5'd0, 5'd4, 32'h12345000, 3'd5, 9'b000010000)};
    tab[10] = '{32'hFFFFF317, mk(4'd7, 5'd0, 5'd0, 5'd6, 32'hFFFFF000, 3'd7, 9'b000010000)};
    tab[11] = '{32'h0020B1B3, mk(4'd11, 5'd1, 5'd2, 5'd3, 32'h0, 3'd3, 9'b000010000)};
    tab[12] = '{32'h022081B3, mk(4'd0, 5'd0, 5'd0, 5'd0, 32'h0, 3'd0, 9'b000000001)};
    tab[13] = '{32'h0234D413, mk(4'd0, 5'd0, 5'd0, 5'd0, 32'h0, 3'd5, 9'b000000001)};

    repeat (2) @(negedge clk);
    check_eq("rst_valid", out_valid_o, 0);
    check_eq("rst_pc", pc_o, 0);
    check_eq("rst_imm", imm_o, 0);
    check_eq("rst_alu", aluctr_o, 0);
    check_eq("rst_ctrl", {branch_o, memread_o, memtoreg_o, memwrite_o, regwrite_o,
                          immadd_o, jump_o, illegal_o}, 0);
    check_eq("rst_ready", in_ready_o, 1);
    rst = 1'b0;

    // Decode sweep, full throughput
    for (int i = 0; i < 14; i++)
      step(1, tab[i].instr, 32'h1000 + 32'(i) * 4, tab[i].e, 0, 0, 5'd0, 1, 0);
    step(0, 32'h0, 32'h0, nil, 0, 0, 5'd0, 1, 0);

    // Load-use hazards
    step(1, 32'h00128333, 32'h2000, e_add656, 0, 1, 5'd5, 1, 1);
    step(1, 32'h00128333, 32'h2000, e_add656, 0, 0, 5'd5, 1, 0);
    step(1, 32'h00128333, 32'h2004, e_add656, 0, 1, 5'd1, 1, 1);
    step(1, 32'h00128333, 32'h2004, e_add656, 0, 1, 5'd6, 1, 0);
    step(1, 32'hFFF00293, 32'h2008, e_addi,   0, 1, 5'd31, 1, 0);
    step(1, 32'hFFF00293, 32'h200C, e_addi,   0, 1, 5'd0, 1, 0);
    step(0, 32'h00128333, 32'h2010, e_add656, 0, 1, 5'd5, 1, 0);

    // Backpressure
    step(1, 32'h0020C1B3, 32'h3000, e_xor, 0, 0, 5'd0, 1, 0);
    for (int i = 0; i < 3; i++)
      step(1, 32'h404183B3, 32'h3004, e_sub, 0, 0, 5'd0, 0, 0);
    step(1, 32'h404183B3, 32'h3004, e_sub, 0, 0, 5'd0, 1, 0);
    step(0, 32'h0, 32'h0, nil, 0, 0, 5'd0, 1, 0);

    // Flush of incoming and of held bundles
    step(1, 32'h00208463, 32'h4000, e_beq, 1, 0, 5'd0, 1, 0);
    step(0, 32'h0, 32'h0, nil, 0, 0, 5'd0, 1, 0);
    step(1, 32'h00208463, 32'h4004, e_beq, 0, 0, 5'd0, 1, 0);
    step(0, 32'h0, 32'h0, nil, 0, 0, 5'd0, 0, 0);
    step(0, 32'h0, 32'h0, nil, 1, 0, 5'd0, 0, 0);
    step(1, 32'h00128333, 32'h4008, e_add656, 1, 1, 5'd5, 1, 1);
    step(0, 32'h0, 32'h0, nil, 0, 0, 5'd0, 1, 0);

    // Illegal word, then asynchronous reset with a bundle held
    step(1, 32'hFFFFFFFF, 32'h5000, e_ill, 0, 0, 5'd0, 1, 0);
    step(1, 32'h002081B3, 32'h5004, e_add, 0, 0, 5'd0, 1, 0);
    rst = 1'b1;
    #1;
    check_eq("async_rst_valid", out_valid_o, 0);
    m_valid = 1'b0; sb.delete(); m_stall = 0;
    in_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1, 32'h002081B3, 32'h6000, e_add, 0, 0, 5'd0, 1, 0);
    step(0, 32'h0, 32'h0, nil, 0, 0, 5'd0, 1, 0);
    step(0, 32'h0, 32'h0, nil, 0, 0, 5'd0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
Registered, parametrised RV32I decode stage between the IF and EX pipeline registers. It accepts instructions with a valid/ready handshake and performs full RV32I base-integer decode (all ALU ops, sign-extended immediates). It detects load-use hazards against EX and supports branch flush. One output register holds the decoded bundle.

Parameters:
XLEN, 32, datapath width; immediate and PC width.
REG_ADDR_WIDTH, 5, register address width.
ALUCTR_W, 4, aluctr_o width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid_i  in  1  instr_i/pc_i valid.
in_ready_o  out  1  stage accepts input this cycle.
instr_i  in  32  instruction word.
pc_i  in  XLEN  instruction PC.
flush_i  in  1  kill held and incoming instruction.
ex_memread_i  in  1  instruction in EX is a load.
ex_rd_i  in  REG_ADDR_WIDTH  EX destination register.
out_valid_o  out  1  decoded bundle valid.
out_ready_i  in  1  EX accepts bundle.
pc_o  out  XLEN  registered PC.
rs1_addr_o, rs2_addr_o, rd_addr_o  out  REG_ADDR_WIDTH  register addresses (0 when unused).
imm_o  out  XLEN  sign-extended immediate.
funct_o  out  3  funct3.
aluctr_o  out  ALUCTR_W  ALU operation.
branch_o, memread_o, memtoreg_o, memwrite_o, regwrite_o, immadd_o  out  1 each  control bits.
jump_o  out  2  00 none, 01 JAL, 10 JALR.
illegal_o  out  1  unknown opcode or funct.

Behaviour:
- Reset (async, rst=1): every output register 0; out_valid_o=0; in_ready_o follows its equation.
- Opcodes: R 0110011, I 0010011, L 0000011, S 0100011, B 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
- Any other opcode: all control bits 0, rd/rs 0, illegal_o=1. The instruction still flows as a valid bundle.
- aluctr encoding:
  - 0 none, 1 add, 2 sub, 3 and, 4 sll, 5 srl, 6 lui-pass, 7 auipc.
  - 8 or, 9 xor, 10 slt, 11 sltu, 12 sra.
- R-type uses funct7[5] for sub/sra. I-type uses imm[10] for srai. Shift-imm with funct7 not 0000000/0100000 sets illegal_o.
- Immediates: I/L/JALR {instr[31:20]}; S {instr[31:25],instr[11:7]}; B {[31],[7],[30:25],[11:8],0}; J {[31],[19:12],[20],[30:21],0}.
- I, L, JALR, S, B and J immediates are sign-extended from bit 31 to XLEN. U-type immediate is instr[31:12]<<12, sign-extended.
- Control bits:
  - L: memread, memtoreg, regwrite, immadd, aluctr=add.
  - S: memwrite, immadd, add.
  - B: branch.
  - JAL: jump_o=01, regwrite.
  - JALR: jump_o=10, regwrite.
  - rd=0 forces regwrite_o=0.
- Uses: rs1 used by R/I/L/S/B/JALR. rs2 used by R/S/B.
- hazard = ex_memread_i && ex_rd_i!=0 && in_valid_i && ((rs1 used && rs1==ex_rd_i) || (rs2 used && rs2==ex_rd_i)).
- Handshake:
  - in_ready_o = (!out_valid_o || out_ready_i) && !hazard. in_ready_o does not depend on flush_i.
  - Input transfer: in_valid_i && in_ready_o, unless flush_i. Output register loads on transfer.
  - If the register frees (out_valid_o consumed or empty) with no transfer, out_valid_o goes 0; a hazard produces exactly this bubble.
  - Held bundle is stable while out_valid_o && !out_ready_i.
- Latency: one cycle, input transfer to out_valid_o.
- flush_i (priority over everything except rst): next cycle out_valid_o=0. Incoming instruction is dropped even if in_ready_o=1. Hazard is ignored that cycle.

Optional Feature:
ID_STALL_CNT_EN: when defined, adds port stall_cnt_o out 32.
- Counts cycles where hazard=1 and flush_i=0.
- Saturates at 0xFFFFFFFF; reset to 0 by rst.
When not defined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- add x3,x1,x2 (0x002081B3), out_ready_i=1 -> next cycle out_valid_o=1, aluctr_o=1, regwrite_o=1, rs1=1, rs2=2, rd=3.
- addi x5,x0,-1 (0xFFF00293) -> imm_o=0xFFFFFFFF, immadd_o=1, aluctr_o=1.
- ex_memread_i=1, ex_rd_i=5, instr add x6,x5,x1 -> in_ready_o=0, one bubble (out_valid_o=0). Drop ex_memread_i -> bundle issues next cycle. With ID_STALL_CNT_EN, stall_cnt_o=1.
- out_ready_i=0 for 3 cycles with a valid bundle held -> outputs unchanged and in_ready_o=0; out_ready_i=1 -> next instruction loads.
- flush_i=1 together with a valid beq (0x00208463) -> next cycle out_valid_o=0. imm_o for unflushed beq = 8, branch_o=1.
- instr 0xFFFFFFFF -> illegal_o=1, all control bits 0. Assert rst mid-stream -> out_valid_o=0 immediately (asynchronous).
